exception_arbiter: RTL and testbench

EXCEPTION_ARBITER -- requirements
Module: exception_arbiter

---
 rtl/exception_arbiter_pkg.sv | 17 +
 rtl/exc_priority_enc.sv | 36 +++
 rtl/exception_arbiter.sv | 92 +++++++++
 tb/tb_exception_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/exception_arbiter_pkg.sv
// Shared encodings for the exception arbiter: FSM states and exception cause codes.
package exception_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQ     = 2'b01,
    ST_HANDLER = 2'b10
  } state_t;

  typedef logic [1:0] ex_type_t;

  localparam ex_type_t EX_INPUT    = 2'd0;
  localparam ex_type_t EX_OVFL     = 2'd1;
  localparam ex_type_t EX_ACCINV   = 2'd2;
  localparam ex_type_t EX_MISALIGN = 2'd3;

endpackage

// File: rtl/exc_priority_enc.sv
// Masked priority encoder: AccInv > Misalign > ovfl > ready input interrupt.
// Also flags a sync source that is high while its enable bit is clear.
module exc_priority_enc
  import exception_arbiter_pkg::*;
(
  input  logic       ovfl,
  input  logic       acc_inv,
  input  logic       misalign,
  input  logic       input_ready,
  input  logic [3:0] enable_mask,
  output logic       valid,
  output ex_type_t   ex_type,
  output logic       masked_sync
);

  always_comb begin
    valid   = 1'b1;
    ex_type = EX_INPUT;
    if (acc_inv && enable_mask[2]) begin
      ex_type = EX_ACCINV;
    end else if (misalign && enable_mask[3]) begin
      ex_type = EX_MISALIGN;
    end else if (ovfl && enable_mask[1]) begin
      ex_type = EX_OVFL;
    end else if (input_ready && enable_mask[0]) begin
      ex_type = EX_INPUT;
    end else begin
      valid = 1'b0;
    end
  end

  assign masked_sync = (ovfl     && !enable_mask[1]) ||
                       (acc_inv  && !enable_mask[2]) ||
                       (misalign && !enable_mask[3]);

endmodule

// File: rtl/exception_arbiter.sv
// Exception arbiter: picks one sync exception or pending input interrupt,
// hands it to the core sequencer and tracks kernel mode until handler completion.
module exception_arbiter
  import exception_arbiter_pkg::*;
#(
  parameter int DROP_W = 8
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              ovfl,
  input  logic              AccInv,
  input  logic              Misalign,
  input  logic              InputRecv,
  input  logic              boundary,
  input  logic [3:0]        enable_mask,
  input  logic              exc_ack,
  input  logic              exc_done,
  output logic              exc_req,
  output logic [1:0]        ExType,
  output logic              KernelMode,
  output logic              InputRst,
  output logic [DROP_W-1:0] drop_count
);

  state_t            state_reg, state_next;
  ex_type_t          ex_type_reg;
  logic              pending_reg;
  logic              input_rst_reg;
  logic [DROP_W-1:0] drop_reg;

  logic     enc_valid;
  ex_type_t enc_type;
  logic     masked_sync;

  exc_priority_enc u_prio (
    .ovfl        (ovfl),
    .acc_inv     (AccInv),
    .misalign    (Misalign),
    .input_ready (pending_reg && boundary),
    .enable_mask (enable_mask),
    .valid       (enc_valid),
    .ex_type     (enc_type),
    .masked_sync (masked_sync)
  );

  logic any_sync, take_req, ack_ok, input_clear, drop_hit;
  assign any_sync    = ovfl || AccInv || Misalign;
  assign take_req    = (state_reg == ST_IDLE) && enc_valid;
  assign ack_ok      = (state_reg == ST_REQ) && exc_ack;
  assign input_clear = ack_ok && (ex_type_reg == EX_INPUT);
  // Outside IDLE every sync source is dropped; inside IDLE only masked ones.
  assign drop_hit    = (state_reg == ST_IDLE) ? masked_sync : any_sync;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:    if (enc_valid) state_next = ST_REQ;
      ST_REQ:     if (exc_ack)   state_next = ST_HANDLER;
      ST_HANDLER: if (exc_done)  state_next = ST_IDLE;
      default:                   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    exc_req    = (state_reg == ST_REQ);
    KernelMode = (state_reg == ST_HANDLER);
    ExType     = ex_type_reg;
    InputRst   = input_rst_reg;
    drop_count = drop_reg;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      ex_type_reg   <= EX_INPUT;
      pending_reg   <= 1'b0;
      input_rst_reg <= 1'b0;
      drop_reg      <= '0;
    end else begin
      if (take_req) ex_type_reg <= enc_type;
      if (input_clear)    pending_reg <= 1'b0;
      else if (InputRecv) pending_reg <= 1'b1;
      input_rst_reg <= input_clear;
      if (drop_hit && (drop_reg != '1)) drop_reg <= drop_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_exception_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_exception_arbiter;

  localparam int DROP_W   = 8;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic              CLK = 1'b0;
  logic              Reset = 1'b0;
  logic              ovfl = 1'b0, AccInv = 1'b0, Misalign = 1'b0;
  logic              InputRecv = 1'b0, boundary = 1'b0;
  logic [3:0]        enable_mask = 4'hF;
  logic              exc_ack = 1'b0, exc_done = 1'b0;
  logic              exc_req;
  logic [1:0]        ExType;
  logic              KernelMode, InputRst;
  logic [DROP_W-1:0] drop_count;

  exception_arbiter #(.DROP_W(DROP_W)) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .ovfl        (ovfl),
    .AccInv      (AccInv),
    .Misalign    (Misalign),
    .InputRecv   (InputRecv),
    .boundary    (boundary),
    .enable_mask (enable_mask),
    .exc_ack     (exc_ack),
    .exc_done    (exc_done),
    .exc_req     (exc_req),
    .ExType      (ExType),
    .KernelMode  (KernelMode),
    .InputRst    (InputRst),
    .drop_count  (drop_count)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Model: "requesting" / "in kernel" flags, pending input, cause, drop tally.
  bit m_req, m_kernel, m_pend, m_rst;
  int m_type, m_drop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_req = 0; m_kernel = 0; m_pend = 0; m_rst = 0; m_type = 0; m_drop = 0;
  endtask

  task automatic model_step();
    bit hit;
    bit any;
    any   = ovfl || AccInv || Misalign;
    m_rst = 0;
    hit   = 0;
    if (!m_req && !m_kernel) begin
      hit = (ovfl && !enable_mask[1]) || (AccInv && !enable_mask[2]) || (Misalign && !enable_mask[3]);
      if (AccInv && enable_mask[2])                   begin m_req = 1; m_type = 2; end
      else if (Misalign && enable_mask[3])            begin m_req = 1; m_type = 3; end
      else if (ovfl && enable_mask[1])                begin m_req = 1; m_type = 1; end
      else if (m_pend && enable_mask[0] && boundary)  begin m_req = 1; m_type = 0; end
      if (InputRecv) m_pend = 1;
    end else if (m_req) begin
      hit = any;
      if (exc_ack) begin
        m_req = 0; m_kernel = 1;
        if (m_type == 0) begin m_rst = 1; m_pend = 0; end
        else if (InputRecv) m_pend = 1;
      end else if (InputRecv) m_pend = 1;
    end else begin
      hit = any;
      if (exc_done) m_kernel = 0;
      if (InputRecv) m_pend = 1;
    end
    if (hit && m_drop < DROP_MAX) m_drop++;
  endtask

  task automatic compare_all(input string tag);
    $display("cycle %s: req=%0b type=%0d kern=%0b rst=%0b drop=%0d", tag, exc_req, ExType, KernelMode, InputRst, drop_count);
    check({tag, "_req"},  32'(exc_req),    32'(m_req));
    check({tag, "_kern"}, 32'(KernelMode), 32'(m_kernel));
    check({tag, "_irst"}, 32'(InputRst),   32'(m_rst));
    check({tag, "_drop"}, 32'(drop_count), 32'(m_drop));
    if (m_req) check({tag, "_type"}, 32'(ExType), 32'(m_type));
  endtask

  task automatic tick(input string tag);
    @(posedge CLK);
    model_step();
    #1;
    compare_all(tag);
  endtask

  task automatic clear_inputs();
    ovfl = 0; AccInv = 0; Misalign = 0; InputRecv = 0;
    boundary = 0; exc_ack = 0; exc_done = 0;
  endtask

  // Asserts reset between clock edges and checks outputs clear without an edge.
  task automatic do_reset();
    Reset = 1'b0;
    clear_inputs();
    #1;
    model_reset();
    check("rst_req",  32'(exc_req),    32'd0);
    check("rst_kern", 32'(KernelMode), 32'd0);
    check("rst_irst", 32'(InputRst),   32'd0);
    check("rst_type", 32'(ExType),     32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    @(negedge CLK);
    Reset = 1'b1;
  endtask

  initial begin
    do_reset();

    // Single enabled ovfl pulse, then ack and done.
    enable_mask = 4'hF;
    ovfl = 1; tick("ovfl"); ovfl = 0;
    check("ovfl_req", 32'(exc_req), 32'd1);
    check("ovfl_type", 32'(ExType), 32'd1);
    tick("ovfl_hold");
    exc_ack = 1; tick("ovfl_ack"); exc_ack = 0;
    check("ovfl_kern", 32'(KernelMode), 32'd1);
    check("ovfl_irst", 32'(InputRst), 32'd0);
    exc_done = 1; tick("ovfl_done"); exc_done = 0;

    // Three sources together: AccInv wins, nothing dropped.
    AccInv = 1; Misalign = 1; ovfl = 1; tick("all3");
    AccInv = 0; Misalign = 0; ovfl = 0;
    check("all3_type", 32'(ExType), 32'd2);
    check("all3_drop", 32'(drop_count), 32'd0);
    exc_ack = 1; tick("all3_ack"); exc_ack = 0;
    exc_done = 1; tick("all3_done"); exc_done = 0;

    // Input interrupt waits for an instruction boundary.
    do_reset();
    InputRecv = 1; tick("in_recv"); InputRecv = 0;
    repeat (5) tick("in_wait");
    check("in_wait_req", 32'(exc_req), 32'd0);
    boundary = 1; tick("in_bnd");
    check("in_req", 32'(exc_req), 32'd1);
    check("in_type", 32'(ExType), 32'd0);
    exc_ack = 1; tick("in_ack"); exc_ack = 0;
    check("in_irst", 32'(InputRst), 32'd1);
    tick("in_after");
    check("in_irst_end", 32'(InputRst), 32'd0);
    exc_done = 1; tick("in_done"); exc_done = 0;

    // Masked ovfl only counts drops, then saturates.
    do_reset();
    enable_mask = 4'b1101;
    ovfl = 1;
    repeat (3) tick("mask");
    check("mask_drop3", 32'(drop_count), 32'd3);
    check("mask_noreq", 32'(exc_req), 32'd0);
    repeat (300) tick("sat");
    ovfl = 0;
    check("sat_drop", 32'(drop_count), 32'd255);
    enable_mask = 4'hF;

    // Input arriving in HANDLER is serviced after return to IDLE.
    do_reset();
    ovfl = 1; tick("h_ovfl"); ovfl = 0;
    exc_ack = 1; tick("h_ack"); exc_ack = 0;
    InputRecv = 1; tick("h_recv"); InputRecv = 0;
    boundary = 1;
    exc_done = 1; tick("h_done"); exc_done = 0;
    check("h_idle_kern", 32'(KernelMode), 32'd0);
    tick("h_req");
    check("h_req_req", 32'(exc_req), 32'd1);
    check("h_req_type", 32'(ExType), 32'd0);
    exc_ack = 1; tick("h_ack2"); exc_ack = 0;
    exc_done = 1; tick("h_done2"); exc_done = 0;

    // Reset while requesting clears outputs asynchronously.
    do_reset();
    Misalign = 1; tick("r_req"); Misalign = 0;
    check("r_req_on", 32'(exc_req), 32'd1);
    do_reset();
    repeat (5) tick("r_idle");

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) enable_mask = 4'($urandom);
      ovfl      = ($urandom_range(0, 9) == 0);
      AccInv    = ($urandom_range(0, 14) == 0);
      Misalign  = ($urandom_range(0, 14) == 0);
      InputRecv = ($urandom_range(0, 19) == 0);
      boundary  = ($urandom_range(0, 1) == 0);
      exc_ack   = ($urandom_range(0, 2) == 0);
      exc_done  = ($urandom_range(0, 4) == 0);
      tick("rnd");
    end
    clear_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
